// File: rtl/hwpe_ctrl_ucode_seq_pkg.sv
// Shared types and constants for the microcode loop sequencer.
//   ucode_t        : loop descriptors (op-list address/length), op slots, loop ranges
//   ctrl_ucode_t   : run/stall enable, synchronous clear, accumulation loop level
//   flags_ucode_t  : done, valid, offset registers, loop indices, accumulate flag
package hwpe_ctrl_ucode_seq_pkg;

    localparam int unsigned UCODE_NB_LOOPS   = 6;
    localparam int unsigned UCODE_NB_REG     = 4;
    localparam int unsigned UCODE_NB_RO_REG  = 28;
    localparam int unsigned UCODE_LENGTH     = 16;
    localparam int unsigned UCODE_CNT_WIDTH  = 12;
    localparam int unsigned UCODE_NB_TOT_REG = UCODE_NB_REG + UCODE_NB_RO_REG;
    localparam int unsigned UCODE_LOOP_W     = $clog2(UCODE_NB_LOOPS);
    localparam int unsigned UCODE_PTR_W      = $clog2(UCODE_LENGTH);
    localparam int unsigned UCODE_OPS_W      = 5;
    localparam int unsigned UCODE_RIDX_W     = $clog2(UCODE_NB_TOT_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } ucode_seq_state_e;

    typedef struct packed {
        logic [4:0]             ucode_addr;
        logic [UCODE_OPS_W-1:0] nb_ops;
    } ucode_loop_t;

    typedef struct packed {
        logic                    op_sel;
        logic [UCODE_RIDX_W-1:0] a;
        logic [UCODE_RIDX_W-1:0] b;
    } ucode_op_t;

    typedef struct packed {
        ucode_loop_t [UCODE_NB_LOOPS-1:0]                       loops;
        ucode_op_t   [UCODE_LENGTH-1:0]                         code;
        logic        [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0]  range;
    } ucode_t;

    typedef struct packed {
        logic                    enable;
        logic                    clear;
        logic [UCODE_LOOP_W-1:0] accum_loop;
    } ctrl_ucode_t;

    typedef struct packed {
        logic                                           done;
        logic                                           valid;
        logic [UCODE_NB_REG-1:0][31:0]                  offs;
        logic [UCODE_NB_LOOPS-1:0][UCODE_CNT_WIDTH-1:0] idx;
        logic                                           accum;
    } flags_ucode_t;

    // A programmed range of zero behaves as a single-iteration loop.
    function automatic logic [UCODE_CNT_WIDTH-1:0] eff_range(input logic [UCODE_CNT_WIDTH-1:0] r);
        return (r == '0) ? UCODE_CNT_WIDTH'(1) : r;
    endfunction

endpackage

// File: rtl/hwpe_ctrl_ucode_seq_alu.sv
// Combinational microcode ALU: selects operands from the unified register
// space (R0..R3 offsets, R4..R31 read-only), computes add or move, and
// decodes whether the destination is writable.
//   op        in  : op slot being executed
//   offs      in  : current offset registers R0..R3
//   registers in  : read-only registers R4..R31
//   we        out : destination is a writable offset register
//   waddr     out : offset register index to write
//   wdata     out : result value
module hwpe_ctrl_ucode_seq_alu
    import hwpe_ctrl_ucode_seq_pkg::*;
(
    input  ucode_op_t                          op,
    input  logic [UCODE_NB_REG-1:0][31:0]      offs,
    input  logic [UCODE_NB_RO_REG-1:0][31:0]   registers,
    output logic                               we,
    output logic [$clog2(UCODE_NB_REG)-1:0]    waddr,
    output logic [31:0]                        wdata
);

    logic [31:0] rf [UCODE_NB_TOT_REG];
    logic [31:0] op_a;
    logic [31:0] op_b;

    for (genvar k = 0; k < UCODE_NB_REG; k++) begin : g_rf_offs
        assign rf[k] = offs[k];
    end
    for (genvar k = 0; k < UCODE_NB_RO_REG; k++) begin : g_rf_ro
        assign rf[UCODE_NB_REG + k] = registers[k];
    end

    assign op_a  = rf[op.a];
    assign op_b  = rf[op.b];
    assign wdata = op.op_sel ? (op_a + op_b) : op_b;
    // Writes aimed at the read-only range are dropped; the op still takes its cycle.
    assign we    = (op.a < UCODE_RIDX_W'(UCODE_NB_REG));
    assign waddr = op.a[$clog2(UCODE_NB_REG)-1:0];

endmodule

// File: rtl/hwpe_ctrl_ucode_seq.sv
// Microcode loop sequencer. Walks up to NB_LOOPS nested loops (loop 0
// innermost), runs the op list attached to the loop that carries on each
// iteration, and emits one flags beat per iteration.
//   clk_i        in  : clock
//   rst_i        in  : synchronous active-high reset
//   ctrl_i       in  : enable (run/stall), clear (sync restart), accum_loop
//   ucode_i      in  : loop descriptors, op slots and ranges (stable while running)
//   registers_i  in  : read-only registers R4..R31
//   flags_o      out : done, valid, offs, idx, accum
module hwpe_ctrl_ucode_seq
    import hwpe_ctrl_ucode_seq_pkg::*;
#(
    parameter int unsigned NB_LOOPS  = UCODE_NB_LOOPS,
    parameter int unsigned NB_REG    = UCODE_NB_REG,
    parameter int unsigned NB_RO_REG = UCODE_NB_RO_REG,
    parameter int unsigned LENGTH    = UCODE_LENGTH,
    parameter int unsigned CNT_WIDTH = UCODE_CNT_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  ctrl_ucode_t                 ctrl_i,
    input  ucode_t                      ucode_i,
    input  logic [NB_RO_REG-1:0][31:0]  registers_i,
    output flags_ucode_t                flags_o
);

    if (NB_LOOPS != UCODE_NB_LOOPS || NB_REG != UCODE_NB_REG || NB_RO_REG != UCODE_NB_RO_REG ||
        LENGTH != UCODE_LENGTH || CNT_WIDTH != UCODE_CNT_WIDTH) begin : g_param_check
        $error("hwpe_ctrl_ucode_seq: parameters must match package constants");
    end

    ucode_seq_state_e state_q, state_d;

    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_q, idx_adv;
    logic [NB_REG-1:0][31:0]            offs_q;
    logic [UCODE_PTR_W-1:0]             ptr_q;
    logic [UCODE_OPS_W-1:0]             cnt_q;
    logic [UCODE_LOOP_W-1:0]            lvl_q;

    logic                               found;
    logic [UCODE_LOOP_W-1:0]            carry_lvl;
    logic [UCODE_LOOP_W-1:0]            adv_lvl;
    logic [UCODE_OPS_W-1:0]             emit_nb_ops;
    logic                               last_op;
    logic                               adv_en;
    logic                               unused_addr_msb;

    logic                               alu_we;
    logic [$clog2(NB_REG)-1:0]          alu_waddr;
    logic [31:0]                        alu_wdata;

    // Lowest loop that has not reached its last iteration; scanning downward
    // lets the innermost candidate overwrite the outer ones.
    always_comb begin
        found     = 1'b0;
        carry_lvl = '0;
        for (int l = NB_LOOPS - 1; l >= 0; l--) begin
            if (idx_q[l] != eff_range(ucode_i.range[l]) - CNT_WIDTH'(1)) begin
                found     = 1'b1;
                carry_lvl = UCODE_LOOP_W'(l);
            end
        end
    end

    // Only the lower address bits select an op slot.
    always_comb begin
        unused_addr_msb = 1'b0;
        for (int l = 0; l < NB_LOOPS; l++) begin
            unused_addr_msb = unused_addr_msb ^ ucode_i.loops[l].ucode_addr[4];
        end
    end

    assign emit_nb_ops = ucode_i.loops[carry_lvl].nb_ops;
    assign last_op     = (cnt_q == UCODE_OPS_W'(1));
    // In EXEC the carry level was latched at EMIT time; in EMIT it is live.
    assign adv_lvl     = (state_q == EXEC) ? lvl_q : carry_lvl;
    assign adv_en      = ctrl_i.enable &&
                         (((state_q == EMIT) && found && (emit_nb_ops == '0)) ||
                          ((state_q == EXEC) && last_op));

    always_comb begin
        for (int l = 0; l < NB_LOOPS; l++) begin
            if (UCODE_LOOP_W'(l) < adv_lvl) begin
                idx_adv[l] = '0;
            end else if (UCODE_LOOP_W'(l) == adv_lvl) begin
                idx_adv[l] = idx_q[l] + CNT_WIDTH'(1);
            end else begin
                idx_adv[l] = idx_q[l];
            end
        end
    end

    hwpe_ctrl_ucode_seq_alu i_alu (
        .op        (ucode_i.code[ptr_q]),
        .offs      (offs_q),
        .registers (registers_i),
        .we        (alu_we),
        .waddr     (alu_waddr),
        .wdata     (alu_wdata)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_i.clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; without enable every state holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ctrl_i.enable) state_d = EMIT;
            EMIT: begin
                if (ctrl_i.enable) begin
                    if (!found) begin
                        state_d = DONE;
                    end else if (emit_nb_ops != '0) begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: if (ctrl_i.enable && last_op) state_d = EMIT;
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        flags_o       = '0;
        flags_o.done  = (state_q == DONE);
        flags_o.valid = ctrl_i.enable && (state_q == EMIT);
        flags_o.offs  = offs_q;
        flags_o.idx   = idx_q;
        flags_o.accum = 1'b1;
        for (int l = 0; l < NB_LOOPS; l++) begin
            if ((UCODE_LOOP_W'(l) < ctrl_i.accum_loop) && (idx_q[l] != '0)) begin
                flags_o.accum = 1'b0;
            end
        end
    end

    // Loop counters, op pointer and offset registers
    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_i.clear) begin
            idx_q  <= '0;
            offs_q <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
            lvl_q  <= '0;
        end else if (ctrl_i.enable) begin
            case (state_q)
                EMIT: begin
                    if (found && (emit_nb_ops != '0)) begin
                        lvl_q <= carry_lvl;
                        ptr_q <= ucode_i.loops[carry_lvl].ucode_addr[UCODE_PTR_W-1:0];
                        cnt_q <= emit_nb_ops;
                    end
                end
                EXEC: begin
                    ptr_q <= ptr_q + UCODE_PTR_W'(1);
                    cnt_q <= cnt_q - UCODE_OPS_W'(1);
                    if (alu_we) begin
                        offs_q[alu_waddr] <= alu_wdata;
                    end
                end
                default: ;
            endcase
            if (adv_en) begin
                idx_q <= idx_adv;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_ctrl_ucode_seq.sv
module tb_hwpe_ctrl_ucode_seq;
    import hwpe_ctrl_ucode_seq_pkg::*;

    logic                              clk = 1'b0;
    logic                              rst;
    ctrl_ucode_t                       ctrl;
    ucode_t                            ucode;
    logic [UCODE_NB_RO_REG-1:0][31:0]  regs;
    flags_ucode_t                      flags;

    typedef struct {
        int           cyc;
        flags_ucode_t f;
    } exp_t;

    exp_t         sb[$];
    int           errors = 0;
    int           checks = 0;
    flags_ucode_t idle_f;

    always #5 clk = ~clk;

    hwpe_ctrl_ucode_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ctrl_i      (ctrl),
        .ucode_i     (ucode),
        .registers_i (regs),
        .flags_o     (flags)
    );

    function automatic flags_ucode_t mk(input int i0, input int i1, input logic [31:0] o0,
                                        input logic [31:0] o1, input logic acc, input logic vld);
        flags_ucode_t f;
        f         = '0;
        f.valid   = vld;
        f.idx[0]  = 12'(i0);
        f.idx[1]  = 12'(i1);
        f.offs[0] = o0;
        f.offs[1] = o1;
        f.accum   = acc;
        return f;
    endfunction

    task automatic push(input int cyc, input flags_ucode_t f);
        exp_t e;
        e.cyc = cyc;
        e.f   = f;
        sb.push_back(e);
    endtask

    task automatic chk_flags(input string tag, input flags_ucode_t obs, input flags_ucode_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Restart through clear; returns on a falling edge with the DUT idle.
    task automatic clear_seq();
        @(negedge clk);
        ctrl.clear  = 1'b1;
        ctrl.enable = 1'b0;
        @(negedge clk);
        ctrl.clear = 1'b0;
        chk_flags("clear_state", flags, idle_f);
    endtask

    // Enable the sequencer and score every valid beat against the queue,
    // optionally stalling for pause_len cycles after falling edge pause_at.
    task automatic run(input string tag, input int exp_done, input int pause_at, input int pause_len);
        int           n;
        bit           done_seen;
        flags_ucode_t snap;
        exp_t         e;
        n           = 0;
        done_seen   = 1'b0;
        snap        = '0;
        ctrl.enable = 1'b1;
        while (!done_seen && n < exp_done + 20) begin
            @(negedge clk);
            n++;
            chk_int({tag, "_excl"}, int'(flags.valid && flags.done), 0);
            if (pause_len > 0 && n > pause_at && n <= pause_at + pause_len) begin
                chk_flags({tag, "_frozen"}, flags, snap);
                if (n == pause_at + pause_len) ctrl.enable = 1'b1;
            end else if (flags.valid) begin
                chk_int({tag, "_extra_valid"}, int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk_flags({tag, "_beat"}, flags, e.f);
                    chk_int({tag, "_beat_cyc"}, n, e.cyc);
                end
            end
            if (flags.done) begin
                done_seen = 1'b1;
                chk_int({tag, "_done_cyc"}, n, exp_done);
                chk_int({tag, "_missing_beats"}, sb.size(), 0);
            end
            if (pause_len > 0 && n == pause_at) begin
                snap        = flags;
                snap.valid  = 1'b0;
                ctrl.enable = 1'b0;
            end
        end
        chk_int({tag, "_done_seen"}, int'(done_seen), 1);
        @(negedge clk);
        chk_int({tag, "_done_hold"}, int'({flags.done, flags.valid}), 2);
        sb.delete();
    endtask

    initial begin
        idle_f       = '0;
        idle_f.accum = 1'b1;
        rst          = 1'b1;
        ctrl         = '0;
        ucode        = '0;
        regs         = '0;

        // Reset state, including with enable raised during reset
        repeat (3) @(negedge clk);
        chk_flags("reset_state", flags, idle_f);
        ctrl.enable = 1'b1;
        @(negedge clk);
        chk_flags("reset_beats_enable", flags, idle_f);
        ctrl.enable = 1'b0;
        rst         = 1'b0;
        @(negedge clk);
        chk_flags("post_reset_idle", flags, idle_f);

        // All ranges zero: a single beat, then done
        push(1, mk(0, 0, 0, 0, 1'b1, 1'b1));
        run("single", 2, 0, 0);
        clear_seq();

        // Two loops {3,2}, no ops: six back-to-back beats
        ucode.range[0] = 12'd3;
        ucode.range[1] = 12'd2;
        for (int i = 0; i < 6; i++) push(i + 1, mk(i % 3, i / 3, 0, 0, 1'b1, 1'b1));
        run("nest", 7, 0, 0);
        clear_seq();

        // Same nest with accumulation over loop 0
        ctrl.accum_loop = 3'd1;
        for (int i = 0; i < 6; i++) push(i + 1, mk(i % 3, i / 3, 0, 0, (i % 3) == 0, 1'b1));
        run("accum3", 7, 0, 0);
        clear_seq();

        // range0=0 behaves as one iteration; accum stays high
        ucode.range[0] = 12'd0;
        push(1, mk(0, 0, 0, 0, 1'b1, 1'b1));
        push(2, mk(0, 1, 0, 0, 1'b1, 1'b1));
        run("accum1", 3, 0, 0);
        clear_seq();

        // Single loop of 4 with R0 += R4 (R4=4)
        ctrl.accum_loop         = 3'd0;
        ucode                   = '0;
        ucode.range[0]          = 12'd4;
        ucode.loops[0].nb_ops   = 5'd1;
        ucode.code[0]           = '{op_sel: 1'b1, a: 5'd0, b: 5'd4};
        regs[0]                 = 32'd4;
        for (int i = 0; i < 4; i++) push(1 + 2 * i, mk(i, 0, 32'(4 * i), 0, 1'b1, 1'b1));
        run("add", 8, 0, 0);
        clear_seq();

        // Same program with a 3-cycle stall in EXEC
        for (int i = 0; i < 4; i++) push((i < 2) ? 1 + 2 * i : 4 + 2 * i, mk(i, 0, 32'(4 * i), 0, 1'b1, 1'b1));
        run("stall", 11, 4, 3);
        clear_seq();

        // Clear during EXEC, then clear held together with enable
        ctrl.enable = 1'b1;
        repeat (4) @(negedge clk);
        chk_flags("pre_clear_exec", flags, mk(1, 0, 32'd4, 0, 1'b1, 1'b0));
        ctrl.clear = 1'b1;
        @(negedge clk);
        chk_flags("clear_in_exec", flags, idle_f);
        @(negedge clk);
        chk_flags("clear_with_enable", flags, idle_f);
        ctrl.clear = 1'b0;
        @(negedge clk);
        chk_flags("restart_after_clear", flags, mk(0, 0, 0, 0, 1'b1, 1'b1));
        clear_seq();

        // Move from RO register, dropped write to R10, op pointer wrapping 15 -> 0
        ucode                 = '0;
        ucode.range[0]        = 12'd2;
        ucode.loops[0]        = '{ucode_addr: 5'd31, nb_ops: 5'd2};
        ucode.code[15]        = '{op_sel: 1'b0, a: 5'd1, b: 5'd5};
        ucode.code[0]         = '{op_sel: 1'b1, a: 5'd10, b: 5'd4};
        regs[1]               = 32'h0000_DEAD;
        push(1, mk(0, 0, 0, 0, 1'b1, 1'b1));
        push(4, mk(1, 0, 0, 32'h0000_DEAD, 1'b1, 1'b1));
        run("move_drop", 5, 0, 0);
        clear_seq();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
